// File: rtl/mem_stage_ext.sv
// MEM-stage load/store unit with a fixed wait-state count.
// Accepts one request at a time, holds the pipeline while the access is
// pending, and returns extended load data with a one-cycle done pulse.
// Storage is split into four independently written byte lanes.

// One byte lane of the data memory: synchronous write, combinational read.
// The array has no reset so that a pipeline reset leaves memory untouched.
module mem_lane #(
  parameter int AW = 12,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  wd,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [0:(2**AW)-1];

  // lane write on the access edge
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  assign rd = mem[idx];

endmodule

module mem_stage_ext #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        exc,
  output logic [1:0]  exc_code
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  // WAIT_CYCLES=0 skips BUSY, so the counter load value is irrelevant there
  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                               state;
  logic [3:0]                           cnt;
  logic                                 is_store;
  logic                                 misalign;
  logic                                 out_of_range;
  logic                                 legal;
  logic                                 accept;
  logic                                 go_acc;
  logic [ADDR_WIDTH-1:0]                word_idx;
  logic [NUM_LANES-1:0]                 lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0]      lane_wd;
  logic [NUM_LANES-1:0][VEC_W-1:0]      lane_rd;
  logic [31:0]                          rd_word;
  logic [7:0]                           rd_byte;
  logic [15:0]                          rd_half;
  logic [31:0]                          ld_ext;

  assign is_store     = (mem_op == OP_SW) || (mem_op == OP_SH) || (mem_op == OP_SB);
  assign out_of_range = |addr[31:ADDR_WIDTH+2];
  assign word_idx     = addr[ADDR_WIDTH+1:2];

  // alignment requirement by access size
  always_comb begin
    misalign = 1'b0;
    case (mem_op)
      OP_LW, OP_SW:         misalign = |addr[1:0];
      OP_LH, OP_LHU, OP_SH: misalign = addr[0];
      default:              misalign = 1'b0;
    endcase
  end

  assign legal  = !misalign && !out_of_range;
  assign accept = reset && (state == IDLE) && req_valid && legal;

  // access happens on the edge that enters DONE; gated by reset so a
  // store still pending when reset asserts never commits
  assign go_acc = reset && (((state == IDLE) && req_valid && legal && (WAIT_CYCLES == 0)) ||
                            ((state == BUSY) && (cnt == 4'd0)));

  assign stall = accept || (reset && (state == BUSY));
  assign done  = (state == DONE);
  assign exc   = reset && (state == IDLE) && req_valid && !legal;

  // misalignment outranks range; code depends on load vs store
  always_comb begin
    exc_code = 2'b00;
    if (exc) begin
      if (misalign) exc_code = is_store ? 2'b10 : 2'b01;
      else          exc_code = 2'b11;
    end
  end

  // sequencer: IDLE -> BUSY (counted) -> DONE -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && legal) begin
            cnt   <= WAIT_M1;
            state <= (WAIT_CYCLES == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      localparam logic [1:0] LI = 2'(g);

      assign lane_we[g] = go_acc && is_store &&
                          ((mem_op == OP_SW) ||
                           ((mem_op == OP_SH) && (addr[1] == LI[1])) ||
                           ((mem_op == OP_SB) && (addr[1:0] == LI)));

      // SH replicates the low halfword, SB the low byte, across lanes
      assign lane_wd[g] = (mem_op == OP_SW) ? wdata[VEC_W*g +: VEC_W] :
                          (mem_op == OP_SH) ? wdata[VEC_W*(g%2) +: VEC_W] :
                                              wdata[VEC_W-1:0];

      mem_lane #(.AW(ADDR_WIDTH), .W(VEC_W)) u_lane (
        .clk (clk),
        .we  (lane_we[g]),
        .idx (word_idx),
        .wd  (lane_wd[g]),
        .rd  (lane_rd[g])
      );
    end
  endgenerate

  assign rd_word = lane_rd;
  assign rd_byte = rd_word[8*addr[1:0] +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  // byte/halfword select and sign/zero extension
  always_comb begin
    ld_ext = rd_word;
    case (mem_op)
      OP_LB:   ld_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ld_ext = {24'd0, rd_byte};
      OP_LH:   ld_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ld_ext = {16'd0, rd_half};
      default: ld_ext = rd_word;
    endcase
  end

  // load result register, held until the next load completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   rdata <= 32'd0;
    else if (go_acc && !is_store) rdata <= ld_ext;
  end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Directed bench for mem_stage_ext: one instance with two wait states and
// one with none; expected values are hand-computed constants.
module tb_mem_stage_ext;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv0, rv1;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, done0, done1, exc0, exc1;
  logic [1:0]  code0, code1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mem_stage_ext #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .stall(stall0), .done(done0), .exc(exc0),
    .exc_code(code0)
  );

  mem_stage_ext #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .stall(stall1), .done(done1), .exc(exc1),
    .exc_code(code1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request to instance d starting just after a rising edge.
  // Returns load data, done cycle (-1 on timeout) and stall-cycle count;
  // ends just after the edge that leaves DONE.
  task automatic run_req(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output int lat, output int nst);
    bit fin;
    mem_op = op; addr = a; wdata = wd;
    if (d == 0) rv0 = 1'b1; else rv1 = 1'b1;
    lat = -1; nst = 0; rd = 32'hx; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      #3;
      if ((d == 0) ? stall0 : stall1) nst++;
      if ((d == 0) ? done0 : done1) begin
        lat = c; rd = (d == 0) ? rdata0 : rdata1;
        rv0 = 1'b0; rv1 = 1'b0; fin = 1;
      end
      @(posedge clk); #1;
    end
    rv0 = 1'b0; rv1 = 1'b0;
  endtask

  // Illegal request in IDLE: exception visible combinationally, no stall,
  // and the block must still be idle after the edge.
  task automatic exc_req(input logic [2:0] op, input logic [31:0] a, input logic [1:0] code,
                         input string tag);
    mem_op = op; addr = a; wdata = 32'hAAAA_AAAA; rv0 = 1'b1;
    #3;
    chk({tag, "_exc"}, 32'(exc0), 32'd1);
    chk({tag, "_code"}, 32'(code0), 32'(code));
    chk({tag, "_stall"}, 32'(stall0), 32'd0);
    @(posedge clk); #3;
    chk({tag, "_idle"}, 32'({stall0, done0}), 32'd0);
    rv0 = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int lat, nst;

  initial begin
    reset = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    mem_op = LW; addr = 32'd0; wdata = 32'd0;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_outs", {rdata0[29:0], stall0, done0}, 32'd0);
    chk("rst_exc", 32'({exc0, code0}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // word store then load, latency 3 with stall in cycles 0-2
    run_req(0, SW, 32'h10, 32'hDEADBEEF, rd, lat, nst);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_nstall", 32'(nst), 32'd3);
    run_req(0, LW, 32'h10, 32'h0, rd, lat, nst);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_data", rd, 32'hDEADBEEF);
    #3; chk("rdata_hold", rdata0, 32'hDEADBEEF);
    @(posedge clk); #1;

    // byte store into lane 3, then word/byte/half reads
    run_req(0, SB, 32'h13, 32'h0000_0055, rd, lat, nst);
    run_req(0, LW, 32'h10, 32'h0, rd, lat, nst);
    chk("sb_lw", rd, 32'h55ADBEEF);
    run_req(0, LB, 32'h13, 32'h0, rd, lat, nst);
    chk("sb_lb", rd, 32'h00000055);
    run_req(0, LH, 32'h12, 32'h0, rd, lat, nst);
    chk("sb_lh", rd, 32'h000055AD);
    run_req(0, SH, 32'h10, 32'hFFFF_1234, rd, lat, nst);
    run_req(0, LW, 32'h10, 32'h0, rd, lat, nst);
    chk("sh_lw", rd, 32'h55AD1234);

    // sign vs zero extension
    run_req(0, SW, 32'h20, 32'h0000F080, rd, lat, nst);
    run_req(0, LB, 32'h20, 32'h0, rd, lat, nst);
    chk("lb_sext", rd, 32'hFFFFFF80);
    run_req(0, LBU, 32'h20, 32'h0, rd, lat, nst);
    chk("lbu_zext", rd, 32'h00000080);
    run_req(0, LH, 32'h20, 32'h0, rd, lat, nst);
    chk("lh_sext", rd, 32'hFFFFF080);
    run_req(0, LHU, 32'h20, 32'h0, rd, lat, nst);
    chk("lhu_zext", rd, 32'h0000F080);
    run_req(0, LB, 32'h21, 32'h0, rd, lat, nst);
    chk("lb_b1", rd, 32'hFFFFFFF0);

    // exceptions; word 0 guards against an out-of-range SW aliasing onto it
    run_req(0, SW, 32'h0, 32'h11111111, rd, lat, nst);
    exc_req(LW, 32'h22, 2'b01, "lw_mis");
    exc_req(SH, 32'h21, 2'b10, "sh_mis");
    exc_req(SW, 32'h4000, 2'b11, "sw_oor");
    exc_req(SW, 32'h4002, 2'b10, "mis_prio");
    chk("exc_rdata_hold", rdata0, 32'hFFFFFFF0);
    run_req(0, LW, 32'h20, 32'h0, rd, lat, nst);
    chk("exc_mem20", rd, 32'h0000F080);
    run_req(0, LW, 32'h0, 32'h0, rd, lat, nst);
    chk("exc_mem0", rd, 32'h11111111);

    // reset during BUSY aborts the store and zeroes outputs
    run_req(0, SW, 32'h30, 32'hCAFEF00D, rd, lat, nst);
    run_req(0, LW, 32'h30, 32'h0, rd, lat, nst);
    mem_op = SW; addr = 32'h30; wdata = 32'h12345678; rv0 = 1'b1;
    @(posedge clk); #3;
    chk("busy_stall", 32'(stall0), 32'd1);
    reset = 1'b0; #1;
    chk("rst_busy_outs", {rdata0[29:0], stall0, done0}, 32'd0);
    rv0 = 1'b0;
    mem_op = LW; addr = 32'h22; rv0 = 1'b1; #1;
    chk("rst_exc_gated", 32'({exc0, code0, stall0}), 32'd0);
    rv0 = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    run_req(0, LW, 32'h30, 32'h0, rd, lat, nst);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_mem", rd, 32'hCAFEF00D);

    // zero wait states: done in cycle 1, back-to-back stores both commit
    run_req(1, SW, 32'h40, 32'hA5A5_0001, rd, lat, nst);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_nstall", 32'(nst), 32'd1);
    run_req(1, SW, 32'h44, 32'h5A5A_0002, rd, lat, nst);
    run_req(1, LW, 32'h40, 32'h0, rd, lat, nst);
    chk("w0_mem40", rd, 32'hA5A50001);
    run_req(1, LW, 32'h44, 32'h0, rd, lat, nst);
    chk("w0_mem44", rd, 32'h5A5A0002);
    chk("w0_lw_lat", 32'(lat), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ext.md
MEM_STAGE_EXT -- requirements
Module: mem_stage_ext

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the number of word-address bits (depth 2^ADDR_WIDTH x 32-bit words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving the extra access-latency cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: memory request present in the MEM stage.
REQ-006 The block SHALL have port mem_op, input, 3 bits: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address, normally the ALU result.
REQ-008 The block SHALL have port wdata, input, 32 bits: forwarded store data; the low byte or halfword is used for SB/SH.
REQ-009 The block SHALL have port rdata, output, 32 bits: extended load result, valid while done=1.
REQ-010 The block SHALL have port stall, output, 1 bit: the pipeline holds the MEM stage and its inputs stable while this is high.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port exc, output, 1 bit, and port exc_code, output, 2 bits: 01 load misaligned, 10 store misaligned, 11 address out of range.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 A request is legal when the address is aligned (LW/SW: addr[1:0]=0; LH/LHU/SH: addr[0]=0; bytes: any) and addr[31:ADDR_WIDTH+2]=0.
REQ-015 In IDLE with req_valid=1 and the request illegal, exc SHALL be 1 combinationally in the same cycle, exc_code SHALL report the fault (misalignment has priority over range), stall SHALL be 0, there SHALL be no memory access, and the state SHALL remain IDLE.
REQ-016 In IDLE with a legal request, stall SHALL be 1 and the next state SHALL be BUSY, or DONE if WAIT_CYCLES=0; the wait counter SHALL load WAIT_CYCLES-1.
REQ-017 In BUSY, stall SHALL be 1 and the counter SHALL decrement each cycle; when the counter reaches 0, the next state SHALL be DONE.
REQ-018 The access SHALL occur on the clock edge entering DONE: a store commits its byte lanes; a load captures rdata into a register.
REQ-019 In DONE, done SHALL be 1, stall SHALL be 0, and the next state SHALL be IDLE unconditionally; req_valid is ignored in DONE.
REQ-020 A legal request SHALL have total latency of WAIT_CYCLES+1 stall cycles, with done in cycle WAIT_CYCLES+1 after acceptance.
REQ-021 Back-to-back requests: a request present in the IDLE cycle after DONE SHALL be treated as new.
REQ-022 Store lanes: SW writes all 4 bytes; SH writes bytes {addr[1],0} and {addr[1],1} from wdata[15:0]; SB writes byte addr[1:0] from wdata[7:0]; other lanes SHALL be unchanged.
REQ-023 Load extension: LB/LH sign-extend and LBU/LHU zero-extend the selected byte or halfword; LW returns the whole word.
REQ-024 mem_op and addr changing during BUSY is a protocol violation; the block SHALL use the values present at the access edge.
REQ-025 Outside DONE, rdata SHALL hold its last captured value; outside IDLE, exc SHALL be 0.

Reset
REQ-026 Reset low SHALL force the state to IDLE immediately and clear the counter, with rdata=0, stall=0, done=0, exc=0 and exc_code=0.
REQ-027 A store pending in BUSY when reset asserts SHALL NOT be committed.
REQ-028 Reset SHALL NOT alter memory contents.
REQ-029 On release of reset, the block SHALL accept requests from the first rising edge.

Verification
REQ-030 WAIT_CYCLES=2, SW addr=0x10, wdata=0xDEADBEEF -> stall=1 in cycles 0-2, done=1 in cycle 3; then LW 0x10 -> rdata=0xDEADBEEF with done in cycle 3.
REQ-031 After that store, SB addr=0x13, wdata=0x55 -> LW 0x10 returns 0x55ADBEEF; LB 0x13 -> 0x00000055; LH 0x12 -> 0x000055AD.
REQ-032 Word 0x20=0x0000F080 -> LB 0x20 = 0xFFFFFF80, LBU 0x20 = 0x00000080, LH 0x20 = 0xFFFFF080, LHU 0x20 = 0x0000F080.
REQ-033 LW addr=0x22 -> exc=1, exc_code=01, stall=0 that cycle; SH addr=0x21 -> exc_code=10; SW addr=0x4000 with ADDR_WIDTH=12 -> exc_code=11; memory is unchanged in all three cases.
REQ-034 With WAIT_CYCLES=0 -> done in cycle 1 after acceptance; two back-to-back SWs both commit.
REQ-035 Reset low during BUSY of SW 0x30=0x12345678 -> outputs are zeroed at once and a later LW 0x30 returns the old value.
